fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single write port of FIFO_top among N requesters.
//  Sits in the write-clock domain, between requester valid/ready interfaces and FIFO_top's write port.
//  Drives i_wren/i_data and honours w_wr_full. Each grant is held for a bounded burst.
// PARAMETERS
//  N_REQ      4   number of requesters (>=2)
//  DATA_W     8   data width; must equal FIFO_top data width
//  MAX_BURST  4   max beats per grant before forced rotation (>=1)
// PORTS
//  i_wclk        in   1             write-domain clock; the only clock
//  i_wrst        in   1             reset, asynchronous, active-high
//  i_req_valid   in   N_REQ         per-requester data valid
//  i_req_data    in   N_REQ*DATA_W  packed data; requester k at [k*DATA_W +: DATA_W]
//  o_req_ready   out  N_REQ         beat accepted from requester k when valid[k]&ready[k]
//  o_gnt         out  N_REQ         one-hot current grant (registered)
//  i_wr_full     in   1             FIFO full flag (w_wr_full)
//  o_wren        out  1             FIFO write enable (to i_wren)
//  o_wdata       out  DATA_W        FIFO write data (to i_data)
//  o_busy        out  1             high while in ARB_GRANT
// BEHAVIOUR
//  Reset (async, while i_wrst=1): state=ARB_IDLE, o_gnt=0, rr_ptr=0, burst_cnt=0.
//   o_wren=0, o_req_ready=0, o_busy=0, o_wdata=0.
//  FSM ARB_IDLE:
//   - if |i_req_valid: winner = first valid index at/after rr_ptr, wrapping mod N_REQ.
//   - o_gnt<=onehot(winner), rr_ptr<=(winner+1)%N_REQ, burst_cnt<=0, go ARB_GRANT.
//   - else stay. Arbitration latency: 1 cycle from valid to grant.
//  FSM ARB_GRANT (g = granted index):
//   - beat = i_req_valid[g] & ~i_wr_full; o_wren = beat (combinational).
//   - o_wdata = data[g] in ARB_GRANT, else 0. o_req_ready[g] = ~i_wr_full; other ready bits 0.
//   - on beat: burst_cnt++.
//   - if beat && burst_cnt==MAX_BURST-1: release.
//   - if i_req_valid[g]==0: release, no beat that cycle.
//   - release: o_gnt<=0, burst_cnt<=0, go ARB_IDLE.
//   - exactly one idle cycle between consecutive grants.
//  Full: i_wr_full=1 stalls without releasing. Grant held, o_wren=0, burst_cnt frozen.
//   - stall cycles do not count toward MAX_BURST. No write is ever issued while i_wr_full=1.
//  Valid drop while full: releases (valid has priority over stall).
//  Simultaneous requests: strict rotation; no requester waits more than N_REQ-1 grants.
//  burst_cnt width $clog2(MAX_BURST+1); rr_ptr width $clog2(N_REQ); wraps N_REQ-1 -> 0.
//  Reset mid-burst: outputs drop immediately with i_wrst. In-flight beat is not written.
//   - after reset, requester 0 has top priority.
//  Inputs other than data[g] have no effect on o_wdata; no X propagation when no grant.
// STRUCTURE
//  fifo_arb_pkg:
//   - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t
//   - localparam helpers for index widths
//  Sub-module fifo_rr_picker: combinational; (req, ptr) -> onehot winner + index.
//   - instantiated once in ARB_IDLE path.
//  Top holds FSM, rr_ptr, burst_cnt, grant register and data mux.
// TESTING (N_REQ=4, DATA_W=8, MAX_BURST=4; FIFO_top with real wren/full)
//  1. i_wrst=1 with all valids high -> o_gnt=0, o_wren=0, o_req_ready=0, o_busy=0.
//  2. Only req2 valid, data 0x10..0x15 (6 beats), full=0:
//     - o_gnt=4'b0100 one cycle after valid; FIFO gets 0x10-0x13 back-to-back.
//     - 1 idle cycle, then re-grant; 0x14,0x15 written.
//  3. All 4 valid continuously:
//     - grant order 0,1,2,3,0; 4 beats each, 1 idle cycle between grants.
//     - read-side data order matches.
//  4. req0 burst; i_wr_full=1 for 3 cycles after beat 2:
//     - o_wren=0 those 3 cycles, o_gnt held; beats 3,4 follow; total 4 beats.
//  5. req1 valid for 1 beat then drops, req3 valid:
//     - req1 released after 1 beat; req3 granted after 1 idle cycle.
//  6. i_wrst pulse during req2 beat 2:
//     - o_wren/o_gnt drop asynchronously; FIFO holds 1 beat.
//     - after release with all valid, req0 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  // index width that stays legal for a 1-entry range
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester side and FIFO write port bundled together; master = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]             i_req_valid;
  logic [N_REQ-1:0][DATA_W-1:0] i_req_data;
  logic [N_REQ-1:0]             o_req_ready;
  logic [N_REQ-1:0]             o_gnt;
  logic                         i_wr_full;
  logic                         o_wren;
  logic [DATA_W-1:0]            o_wdata;
  logic                         o_busy;

  modport master (
    input  i_req_valid, i_req_data, i_wr_full,
    output o_req_ready, o_gnt, o_wren, o_wdata, o_busy
  );

  modport slave (
    output i_req_valid, i_req_data, i_wr_full,
    input  o_req_ready, o_gnt, o_wren, o_wdata, o_busy
  );
endinterface

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin pick: first set request at/after ptr, wrapping.
module fifo_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  logic found;
  int   k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found     = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; bounded bursts, full stalls.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               i_wclk,
  input  logic               i_wrst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int IW = idx_w(N_REQ);
  localparam int CW = cnt_w(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    burst_q, burst_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             busy, g_valid, beat;

  fifo_rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (bus.i_req_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // everything downstream keys off state, so async reset kills outputs at once
  assign busy    = (state_q == ARB_GRANT);
  assign g_valid = bus.i_req_valid[gidx_q];
  assign beat    = busy & g_valid & ~bus.i_wr_full;

  assign bus.o_wren      = beat;
  assign bus.o_wdata     = busy ? bus.i_req_data[gidx_q] : '0;
  assign bus.o_req_ready = (busy & ~bus.i_wr_full) ? gnt_q : '0;
  assign bus.o_gnt       = gnt_q;
  assign bus.o_busy      = busy;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    case (state_q)
      ARB_IDLE: begin
        if (|bus.i_req_valid) begin
          state_d  = ARB_GRANT;
          gnt_d    = pick_oh;
          gidx_d   = pick_idx;
          rr_ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          burst_d  = '0;
        end
      end
      ARB_GRANT: begin
        // a dropped valid releases even while full holds the beat off
        if (!g_valid || (beat && burst_q == CW'(MAX_BURST - 1))) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          burst_d = '0;
        end else if (beat) begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_wclk or posedge i_wrst) begin
    if (i_wrst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
    end
  end
endmodule
